// File: rtl/reel_speed_if.sv
// reel_speed_if: start/stop control, divider drive and step-count status for one reel scheduler.
interface reel_speed_if;
    logic        start;
    logic        stop_req;
    logic        reel_tick;
    logic [19:0] speed;
    logic        div_rst;
    logic        busy;
    logic        done;
    logic [15:0] reel_steps;
    logic [2:0]  phase;
    modport master (output start, stop_req, reel_tick, input speed, div_rst, busy, done, reel_steps, phase);
    modport slave (input start, stop_req, reel_tick, output speed, div_rst, busy, done, reel_steps, phase);
endinterface

// File: rtl/reel_speed_scheduler.sv
// reel_speed_scheduler: ramps a reel's step rate up, cruises, ramps down and parks on a step edge.
// Define RANDOM_HOLD_EN to stretch each cruise by an LFSR-derived amount.
module reel_speed_scheduler #(
    parameter int BASESPEED    = 50000000,
    parameter int MIN_SPEED    = 2,
    parameter int MAX_SPEED    = 40,
    parameter int STEP         = 2,
    parameter int DWELL_CYCLES = 5000000,
    parameter int HOLD_CYCLES  = 50000000
) (
    input logic clk,
    input logic rst,
    reel_speed_if.slave bus
);
    if (BASESPEED < 1 || MIN_SPEED < 1 || MAX_SPEED <= MIN_SPEED || MAX_SPEED >= (1 << 20) ||
        STEP < 1 || DWELL_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_cfg
        $error("reel_speed_scheduler: invalid parameter set");
    end
    typedef enum logic [2:0] {IDLE = 3'd0, ACCEL = 3'd1, CRUISE = 3'd2, DECEL = 3'd3, ALIGN = 3'd4, DONE = 3'd5} state_t;
    state_t      state, state_n;
    logic [19:0] speed, speed_n, spd_up, spd_dn;
    logic [20:0] spd_sum;
    logic [31:0] dwell, dwell_n, hold, hold_n, hold_lim;
    logic [15:0] steps, steps_n;
    logic        div_rst, div_rst_n, tick_q, edge_p, dwell_end;
`ifdef RANDOM_HOLD_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr     <= 16'hACE1;
            hold_lim <= 32'(HOLD_CYCLES);
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            if (state_n == CRUISE && state != CRUISE)
                hold_lim <= 32'(HOLD_CYCLES) + {16'h0000, lfsr[7:0], 8'h00};
        end
    end
`else
    assign hold_lim = 32'(HOLD_CYCLES);
`endif
    assign edge_p    = bus.reel_tick & ~tick_q;
    assign dwell_end = dwell == 32'(DWELL_CYCLES - 1);
    assign spd_sum   = {1'b0, speed} + 21'(STEP);
    assign spd_up    = spd_sum >= 21'(MAX_SPEED) ? 20'(MAX_SPEED) : spd_sum[19:0];
    assign spd_dn    = speed >= 20'(MIN_SPEED + STEP) ? speed - 20'(STEP) : 20'(MIN_SPEED);
    always_comb begin
        state_n   = state;
        speed_n   = speed;
        dwell_n   = dwell;
        hold_n    = hold;
        div_rst_n = 1'b0;
        steps_n   = (state != IDLE && edge_p) ? steps + 16'd1 : steps;
        case (state)
            IDLE: if (bus.start) begin
                state_n   = ACCEL;
                speed_n   = 20'(MIN_SPEED);
                steps_n   = 16'd0;
                div_rst_n = 1'b1;
                dwell_n   = 32'd0;
            end
            ACCEL: if (bus.stop_req) begin
                state_n = DECEL;
                dwell_n = 32'd0;
            end else if (dwell_end) begin
                dwell_n = 32'd0;
                speed_n = spd_up;
                if (spd_up == 20'(MAX_SPEED)) begin
                    state_n = CRUISE;
                    hold_n  = 32'd0;
                end
            end else
                dwell_n = dwell + 32'd1;
            CRUISE: if (bus.stop_req || hold == hold_lim - 32'd1) begin
                state_n = DECEL;
                dwell_n = 32'd0;
            end else
                hold_n = hold + 32'd1;
            // a stop issued at the slowest rate skips straight to alignment
            DECEL: if (speed <= 20'(MIN_SPEED))
                state_n = ALIGN;
            else if (dwell_end) begin
                dwell_n = 32'd0;
                speed_n = spd_dn;
                state_n = spd_dn == 20'(MIN_SPEED) ? ALIGN : DECEL;
            end else
                dwell_n = dwell + 32'd1;
            ALIGN: if (edge_p) begin
                state_n = DONE;
                speed_n = 20'(MIN_SPEED);
            end
            default: begin
                state_n = IDLE;
                speed_n = 20'(MIN_SPEED);
            end
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            speed   <= 20'(MIN_SPEED);
            dwell   <= 32'd0;
            hold    <= 32'd0;
            steps   <= 16'd0;
            div_rst <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state   <= state_n;
            speed   <= speed_n;
            dwell   <= dwell_n;
            hold    <= hold_n;
            steps   <= steps_n;
            div_rst <= div_rst_n;
            tick_q  <= bus.reel_tick;
        end
    end
    assign bus.speed      = speed;
    assign bus.div_rst    = div_rst;
    assign bus.busy       = state != IDLE;
    assign bus.done       = state == DONE;
    assign bus.reel_steps = steps;
    assign bus.phase      = state;
endmodule
